// File: rtl/step_rate_monitor.sv
// Step-rate monitor: counts synchronized rising edges of Pulse over a programmable
// number of CLK_HZ-cycle windows and reports the last rate and the count of over-threshold windows.
module step_rate_monitor #(
  parameter int CLK_HZ    = 1000,
  parameter int THRESHOLD = 32,
  parameter int WINDOWS   = 9,
  parameter int RATE_W    = 8,
  parameter int OVER_W    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Pulse,
  input  logic              start,
  output logic [OVER_W-1:0] steps_over,
  output logic [RATE_W-1:0] rate_last,
  output logic              window_tick,
  output logic              busy,
  output logic              done
);
  localparam int PRE_W = $clog2(CLK_HZ);
  localparam int WIN_W = $clog2(WINDOWS + 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WINDOWS - 1);
  localparam logic [RATE_W-1:0] RATE_MAX = '1;
  localparam logic [OVER_W-1:0] OVER_MAX = '1;
  localparam logic [31:0]       THRESH_U = 32'(THRESHOLD);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [PRE_W-1:0]   presc_q, presc_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [RATE_W-1:0]  rate_cnt_q, rate_cnt_d;
  logic [RATE_W-1:0]  rate_last_q, rate_last_d;
  logic [OVER_W-1:0]  steps_over_q, steps_over_d;

  logic              pulse_edge;
  logic              start_run;
  logic              win_close;
  logic [RATE_W-1:0] rate_n;

  // sync_q[1] is the synchronizer output; sync_q[2] is its one-cycle delay for edge detection.
  assign sync_d     = {sync_q[1:0], Pulse};
  assign pulse_edge = sync_q[1] & ~sync_q[2];
  assign start_run  = start && (state_q == S_IDLE || state_q == S_DONE);
  assign win_close  = (state_q == S_RUN) && (presc_q == PRE_LAST);
  // An edge on the close cycle still belongs to the closing window.
  assign rate_n     = (rate_cnt_q == RATE_MAX) ? RATE_MAX : rate_cnt_q + RATE_W'(pulse_edge);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      sync_q       <= '0;
      presc_q      <= '0;
      win_cnt_q    <= '0;
      rate_cnt_q   <= '0;
      rate_last_q  <= '0;
      steps_over_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      presc_q      <= presc_d;
      win_cnt_q    <= win_cnt_d;
      rate_cnt_q   <= rate_cnt_d;
      rate_last_q  <= rate_last_d;
      steps_over_q <= steps_over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (win_close && win_cnt_q == WIN_LAST) state_d = S_DONE;
      S_DONE:  if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    presc_d      = presc_q;
    win_cnt_d    = win_cnt_q;
    rate_cnt_d   = rate_cnt_q;
    rate_last_d  = rate_last_q;
    steps_over_d = steps_over_q;
    if (start_run) begin
      presc_d      = '0;
      win_cnt_d    = '0;
      rate_cnt_d   = '0;
      steps_over_d = '0;
    end else if (state_q == S_RUN) begin
      if (win_close) begin
        presc_d     = '0;
        win_cnt_d   = win_cnt_q + 1'b1;
        rate_cnt_d  = '0;
        rate_last_d = rate_n;
        if (32'(rate_n) >= THRESH_U && steps_over_q != OVER_MAX)
          steps_over_d = steps_over_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
        if (pulse_edge && rate_cnt_q != RATE_MAX)
          rate_cnt_d = rate_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    window_tick = win_close;
    busy        = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    steps_over  = steps_over_q;
    rate_last   = rate_last_q;
  end
endmodule

// File: tb/tb_step_rate_monitor.sv
// Directed bench for step_rate_monitor: window results are queued at stimulus time
// and checked by per-instance monitors on each window_tick.
module tb_step_rate_monitor;
  // Valid/ready contract: a window result is presented by window_tick (one cycle);
  // rate_last/steps_over/done are read on the following cycle, with no backpressure.
  logic clk = 1'b0;
  logic rst;
  logic pulse_a, start_a, pulse_b, start_b;
  logic [1:0] over_a, over_b;
  logic [3:0] rate_a, rate_b;
  logic tick_a, busy_a, done_a, tick_b, busy_b, done_b;

  logic [6:0] exp_q[$];
  logic [6:0] exp5_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  logic pend_a = 1'b0;
  logic pend_b = 1'b0;

  always #5 clk = ~clk;

  step_rate_monitor #(.CLK_HZ(100), .THRESHOLD(4), .WINDOWS(3), .RATE_W(4), .OVER_W(2)) dut (
    .CLK(clk), .RESET(rst), .Pulse(pulse_a), .start(start_a),
    .steps_over(over_a), .rate_last(rate_a), .window_tick(tick_a), .busy(busy_a), .done(done_a)
  );

  step_rate_monitor #(.CLK_HZ(100), .THRESHOLD(4), .WINDOWS(5), .RATE_W(4), .OVER_W(2)) dut5 (
    .CLK(clk), .RESET(rst), .Pulse(pulse_b), .start(start_b),
    .steps_over(over_b), .rate_last(rate_b), .window_tick(tick_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [6:0] pack(input logic d, input logic [1:0] o, input logic [3:0] r);
    return {d, o, r};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drv_pulse(input bit sel, input logic v);
    if (sel) pulse_b = v; else pulse_a = v;
  endtask

  task automatic drv_start(input bit sel, input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  // Leaves the bench 1 ns into the first RUN cycle (window offset 1).
  task automatic do_start(input bit sel);
    drv_start(sel, 1'b1);
    tick(1);
    drv_start(sel, 1'b0);
  endtask

  // One full window of 100 cycles: n pulses of period 4, an optional start poke,
  // and an optional pulse timed so its edge lands on the close cycle.
  task automatic run_window(input bit sel, input int n, input bit boundary, input bit poke,
                            input logic [6:0] e);
    int used;
    if (sel) exp5_q.push_back(e); else exp_q.push_back(e);
    tick(8);
    used = 8;
    for (int i = 0; i < n; i++) begin
      drv_pulse(sel, 1'b1);
      tick(2);
      drv_pulse(sel, 1'b0);
      tick(2);
      used += 4;
    end
    if (poke) begin
      drv_start(sel, 1'b1);
      tick(1);
      drv_start(sel, 1'b0);
      used += 1;
    end
    if (boundary) begin
      tick(97 - used);
      drv_pulse(sel, 1'b1);
      tick(2);
      drv_pulse(sel, 1'b0);
      tick(1);
    end else begin
      tick(100 - used);
    end
  endtask

  always @(negedge clk) begin
    if (pend_a) begin
      pend_a = 1'b0;
      if (exp_q.size() == 0) check("tick_a_unexpected", 1, 0);
      else check("window_a", {done_a, over_a, rate_a}, exp_q.pop_front());
    end
    if (tick_a) begin
      check("tick_a_busy_done", {busy_a, done_a}, 2'b10);
      pend_a = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (pend_b) begin
      pend_b = 1'b0;
      if (exp5_q.size() == 0) check("tick_b_unexpected", 1, 0);
      else check("window_b", {done_b, over_b, rate_b}, exp5_q.pop_front());
    end
    if (tick_b) begin
      check("tick_b_busy_done", {busy_b, done_b}, 2'b10);
      pend_b = 1'b1;
    end
  end

  initial begin
    rst = 1'b1; pulse_a = 1'b0; start_a = 1'b0; pulse_b = 1'b0; start_b = 1'b0;
    // Reset with Pulse toggling: everything stays at zero.
    for (int i = 0; i < 6; i++) begin
      pulse_a = ~pulse_a;
      pulse_b = ~pulse_b;
      tick(2);
      check("reset_outputs_a", {over_a, rate_a, tick_a, busy_a, done_a}, 9'd0);
    end
    pulse_a = 1'b1; pulse_b = 1'b1;
    rst = 1'b0;
    tick(150);
    check("post_reset_edge_a", {over_a, rate_a, tick_a, busy_a, done_a}, 9'd0);
    check("post_reset_edge_b", {over_b, rate_b, tick_b, busy_b, done_b}, 9'd0);
    pulse_a = 1'b0; pulse_b = 1'b0;
    tick(5);

    // Mixed windows 5/3/4 pulses.
    do_start(0);
    check("start_busy", {busy_a, done_a, over_a}, 4'b1000);
    run_window(0, 5, 0, 0, pack(0, 2'd1, 4'd5));
    run_window(0, 3, 0, 0, pack(0, 2'd1, 4'd3));
    run_window(0, 4, 0, 0, pack(1, 2'd2, 4'd4));
    check("done_t301", {busy_a, done_a, over_a}, 4'b0110);
    tick(3);
    check("done_holds", {busy_a, done_a, over_a, rate_a}, {2'b01, 2'd2, 4'd4});

    // Restart from DONE; rate saturation; start in RUN ignored.
    do_start(0);
    check("restart_clears", {busy_a, done_a, over_a, rate_a}, {2'b10, 2'd0, 4'd4});
    run_window(0, 20, 0, 0, pack(0, 2'd1, 4'd15));
    run_window(0, 0, 0, 1, pack(0, 2'd1, 4'd0));
    run_window(0, 0, 0, 0, pack(1, 2'd1, 4'd0));

    // Edge on the close cycle counts in the closing window only.
    do_start(0);
    run_window(0, 3, 1, 0, pack(0, 2'd1, 4'd4));
    run_window(0, 2, 0, 0, pack(0, 2'd1, 4'd2));
    run_window(0, 4, 0, 0, pack(1, 2'd2, 4'd4));

    // Over-count saturation on the five-window instance.
    do_start(1);
    run_window(1, 4, 0, 0, pack(0, 2'd1, 4'd4));
    run_window(1, 4, 0, 0, pack(0, 2'd2, 4'd4));
    run_window(1, 4, 0, 0, pack(0, 2'd3, 4'd4));
    run_window(1, 4, 0, 0, pack(0, 2'd3, 4'd4));
    run_window(1, 4, 0, 0, pack(1, 2'd3, 4'd4));
    check("over_sat_final", {busy_b, done_b, over_b}, 4'b0111);

    // Abort with RESET in the middle of window 2.
    do_start(0);
    run_window(0, 4, 0, 0, pack(0, 2'd1, 4'd4));
    tick(30);
    rst = 1'b1;
    #1;
    check("abort_async_zero", {over_a, rate_a, tick_a, busy_a, done_a}, 9'd0);
    tick(3);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse_a = 1'b1; tick(2);
      pulse_a = 1'b0; tick(2);
    end
    tick(120);
    check("abort_stays_idle", {over_a, rate_a, tick_a, busy_a, done_a}, 9'd0);
    check("queues_drained", exp_q.size() + exp5_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
